// File: rtl/fmap_mem_responder.sv
// rtl/fmap_mem_responder.sv - membrane-potential feature map with coordinate reads/writes
// and a full-map valid/ready stream
module fmap_mem_responder #(
  parameter int COORD_BITS      = 8,
  parameter int OUT_CHANNELS    = 4,
  parameter int IMG_WIDTH       = 32,
  parameter int IMG_HEIGHT      = 32,
  parameter int BITS_PER_NEURON = 9
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    read_req,
  input  logic [COORD_BITS-1:0]                   read_x,
  input  logic [COORD_BITS-1:0]                   read_y,
  output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] read_data,
  output logic                                    read_valid,
  input  logic                                    write_req,
  input  logic [COORD_BITS-1:0]                   write_x,
  input  logic [COORD_BITS-1:0]                   write_y,
  input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] write_data,
  output logic                                    busy,
  output logic                                    init_done,
  output logic                                    range_err,
  input  logic                                    scan_start,
  input  logic                                    scan_clear,
  output logic                                    scan_valid,
  input  logic                                    scan_ready,
  output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] scan_data,
  output logic [COORD_BITS-1:0]                   scan_x,
  output logic [COORD_BITS-1:0]                   scan_y,
  output logic                                    scan_last
);

  localparam int WORD_W = OUT_CHANNELS * BITS_PER_NEURON;
  localparam int DEPTH  = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [COORD_BITS-1:0] X_MAX     = COORD_BITS'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {S_INIT, S_SERVE, S_SCAN} state_t;

  state_t state, state_n;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0]     ptr;
  logic [COORD_BITS-1:0] sx, sy;
  logic                  clear_q;

  logic                  rd_ok, wr_ok;
  logic [ADDR_W-1:0]     rd_addr, wr_addr;
  logic                  srv_rd, srv_wr;
  logic                  scan_issue, scan_hs;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [WORD_W-1:0]     mem_wdata;

  function automatic logic in_range(input logic [COORD_BITS-1:0] x, input logic [COORD_BITS-1:0] y);
    return (int'(x) < IMG_WIDTH) && (int'(y) < IMG_HEIGHT);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [COORD_BITS-1:0] x, input logic [COORD_BITS-1:0] y);
    return ADDR_W'(int'(y) * IMG_WIDTH + int'(x));
  endfunction

  assign rd_ok   = in_range(read_x, read_y);
  assign wr_ok   = in_range(write_x, write_y);
  assign rd_addr = addr_of(read_x, read_y);
  assign wr_addr = addr_of(write_x, write_y);
  assign busy    = (state != S_SERVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_INIT:  if (ptr == LAST_ADDR) state_n = S_SERVE;
      S_SERVE: if (scan_start) state_n = S_SCAN;
      S_SCAN:  if (scan_hs && scan_last) state_n = S_SERVE;
      default: state_n = S_INIT;
    endcase
  end

  // One write port shared by the init sweep, posted writes and scan-clear.
  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = ptr;
    mem_wdata  = '0;
    srv_rd     = 1'b0;
    srv_wr     = 1'b0;
    scan_issue = 1'b0;
    scan_hs    = 1'b0;
    unique case (state)
      S_INIT: mem_we = 1'b1;
      S_SERVE: begin
        srv_rd    = read_req;
        srv_wr    = write_req && wr_ok;
        mem_we    = srv_wr;
        mem_waddr = wr_addr;
        mem_wdata = write_data;
      end
      S_SCAN: begin
        scan_issue = !scan_valid;
        scan_hs    = scan_valid && scan_ready;
        mem_we     = scan_hs && clear_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      sx        <= '0;
      sy        <= '0;
      clear_q   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        S_INIT: begin
          ptr <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
          if (ptr == LAST_ADDR) init_done <= 1'b1;
        end
        S_SERVE: if (scan_start) begin
          ptr     <= '0;
          sx      <= '0;
          sy      <= '0;
          clear_q <= scan_clear;
        end
        S_SCAN: if (scan_hs) begin
          ptr <= scan_last ? '0 : ptr + 1'b1;
          if (sx == X_MAX) begin
            sx <= '0;
            sy <= sy + 1'b1;
          end else begin
            sx <= sx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Same-cycle write to the read address is forwarded; out-of-range reads return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      read_valid <= srv_rd;
      range_err  <= (state == S_SERVE) && ((read_req && !rd_ok) || (write_req && !wr_ok));
      if (srv_rd) begin
        if (!rd_ok)                          read_data <= '0;
        else if (srv_wr && wr_addr == rd_addr) read_data <= write_data;
        else                                 read_data <= mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_valid <= 1'b0;
      scan_data  <= '0;
      scan_x     <= '0;
      scan_y     <= '0;
      scan_last  <= 1'b0;
    end else if (scan_issue) begin
      scan_valid <= 1'b1;
      scan_data  <= mem[ptr];
      scan_x     <= sx;
      scan_y     <= sy;
      scan_last  <= (ptr == LAST_ADDR);
    end else if (scan_hs) begin
      scan_valid <= 1'b0;
      scan_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fmap_mem_responder.sv
// tb/tb_fmap_mem_responder.sv - directed self-checking bench for fmap_mem_responder
module tb_fmap_mem_responder;

  localparam int W     = 32;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_req = 1'b0;
  logic [7:0]  read_x = '0, read_y = '0;
  logic [35:0] read_data;
  logic        read_valid;
  logic        write_req = 1'b0;
  logic [7:0]  write_x = '0, write_y = '0;
  logic [35:0] write_data = '0;
  logic        busy, init_done, range_err;
  logic        scan_start = 1'b0, scan_clear = 1'b0, scan_ready = 1'b0;
  logic        scan_valid, scan_last;
  logic [35:0] scan_data;
  logic [7:0]  scan_x, scan_y;

  int checks = 0;
  int failures = 0;

  fmap_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .read_req(read_req), .read_x(read_x), .read_y(read_y),
    .read_data(read_data), .read_valid(read_valid),
    .write_req(write_req), .write_x(write_x), .write_y(write_y), .write_data(write_data),
    .busy(busy), .init_done(init_done), .range_err(range_err),
    .scan_start(scan_start), .scan_clear(scan_clear),
    .scan_valid(scan_valid), .scan_ready(scan_ready), .scan_data(scan_data),
    .scan_x(scan_x), .scan_y(scan_y), .scan_last(scan_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [7:0] x, input logic [7:0] y, output logic v, output logic [35:0] d);
    read_req = 1'b1; read_x = x; read_y = y;
    tick();
    read_req = 1'b0;
    v = read_valid;
    d = read_data;
  endtask

  task automatic do_write(input logic [7:0] x, input logic [7:0] y, input logic [35:0] d);
    write_req = 1'b1; write_x = x; write_y = y; write_data = d;
    tick();
    write_req = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int  n;
    bit  leak;
    n = 0;
    leak = 0;
    while (busy === 1'b1 && n < 2000) begin
      read_req = (n == 5); read_x = 8'd40; read_y = 8'd0;
      if (read_valid === 1'b1 || range_err === 1'b1) leak = 1;
      n++;
      tick();
    end
    read_req = 1'b0;
    checks++;
    if (n != 1024) begin
      failures++;
      $display("FAIL %s_busy_cycles got=%0d want=1024", tag, n);
    end
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL %s_init_done got=%b want=1", tag, init_done);
    end
    checks++;
    if (leak) begin
      failures++;
      $display("FAIL %s_busy_drop got=response_during_init want=none", tag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1 || init_done !== 1'b0 || read_valid !== 1'b0 || scan_valid !== 1'b0 ||
        range_err !== 1'b0 || read_data !== 36'h0 || scan_data !== 36'h0 || scan_last !== 1'b0 ||
        scan_x !== 8'h0 || scan_y !== 8'h0) begin
      failures++;
      $display("FAIL reset_values busy=%b init_done=%b read_valid=%b scan_valid=%b range_err=%b read_data=%h want busy=1 rest=0",
               busy, init_done, read_valid, scan_valid, range_err, read_data);
    end
    rst_n = 1'b1;
    wait_init("init");
  endtask

  task automatic test_read_write();
    logic v;
    logic [35:0] d;
    do_read(8'd3, 8'd5, v, d);
    checks++;
    if (v !== 1'b1 || d !== 36'h0) begin
      failures++;
      $display("FAIL first_read valid=%b data=%h want valid=1 data=0", v, d);
    end
    tick();
    checks++;
    if (read_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_valid_one_cycle got=%b want=0", read_valid);
    end
    do_write(8'd3, 8'd5, 36'h0_1234_5678);
    do_read(8'd3, 8'd5, v, d);
    checks++;
    if (v !== 1'b1 || d !== 36'h0_1234_5678) begin
      failures++;
      $display("FAIL write_then_read valid=%b data=%h want valid=1 data=012345678", v, d);
    end
    do_read(8'd4, 8'd5, v, d);
    checks++;
    if (v !== 1'b1 || d !== 36'h0) begin
      failures++;
      $display("FAIL neighbour_read valid=%b data=%h want valid=1 data=0", v, d);
    end
  endtask

  task automatic test_bypass();
    logic v;
    logic [35:0] d;
    write_req = 1'b1; write_x = 8'd7; write_y = 8'd7; write_data = 36'hA_AAAA_AAAA;
    read_req = 1'b1; read_x = 8'd7; read_y = 8'd7;
    tick();
    write_req = 1'b0; read_req = 1'b0;
    checks++;
    if (read_valid !== 1'b1 || read_data !== 36'hA_AAAA_AAAA) begin
      failures++;
      $display("FAIL bypass valid=%b data=%h want valid=1 data=aaaaaaaaa", read_valid, read_data);
    end
    do_read(8'd7, 8'd7, v, d);
    checks++;
    if (d !== 36'hA_AAAA_AAAA) begin
      failures++;
      $display("FAIL bypass_stored got=%h want=aaaaaaaaa", d);
    end
  endtask

  task automatic test_back_to_back();
    read_req = 1'b1; read_x = 8'd3; read_y = 8'd5;
    tick();
    checks++;
    if (read_valid !== 1'b1 || read_data !== 36'h0_1234_5678) begin
      failures++;
      $display("FAIL b2b_0 valid=%b data=%h want valid=1 data=012345678", read_valid, read_data);
    end
    read_x = 8'd7; read_y = 8'd7;
    tick();
    checks++;
    if (read_valid !== 1'b1 || read_data !== 36'hA_AAAA_AAAA) begin
      failures++;
      $display("FAIL b2b_1 valid=%b data=%h want valid=1 data=aaaaaaaaa", read_valid, read_data);
    end
    read_x = 8'd4; read_y = 8'd5;
    tick();
    read_req = 1'b0;
    checks++;
    if (read_valid !== 1'b1 || read_data !== 36'h0) begin
      failures++;
      $display("FAIL b2b_2 valid=%b data=%h want valid=1 data=0", read_valid, read_data);
    end
    tick();
    checks++;
    if (read_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b want=0", read_valid);
    end
  endtask

  task automatic test_range();
    logic v;
    logic [35:0] d;
    do_write(8'd0, 8'd0, 36'h5);
    write_req = 1'b1; write_x = 8'd32; write_y = 8'd0; write_data = 36'hF_FFFF_FFFF;
    read_req = 1'b1; read_x = 8'd0; read_y = 8'd32;
    tick();
    write_req = 1'b0; read_req = 1'b0;
    checks++;
    if (range_err !== 1'b1 || read_valid !== 1'b1 || read_data !== 36'h0) begin
      failures++;
      $display("FAIL range_bad err=%b valid=%b data=%h want err=1 valid=1 data=0", range_err, read_valid, read_data);
    end
    tick();
    checks++;
    if (range_err !== 1'b0) begin
      failures++;
      $display("FAIL range_single_pulse got=%b want=0", range_err);
    end
    do_read(8'd0, 8'd0, v, d);
    checks++;
    if (d !== 36'h5 || range_err !== 1'b0) begin
      failures++;
      $display("FAIL range_origin data=%h err=%b want data=5 err=0", d, range_err);
    end
    do_read(8'd0, 8'd1, v, d);
    checks++;
    if (d !== 36'h0) begin
      failures++;
      $display("FAIL range_alias got=%h want=0", d);
    end
  endtask

  function automatic logic [35:0] scan_expect(input int idx);
    case (idx)
      0:       return 36'h1;
      163:     return 36'h0_1234_5678;
      231:     return 36'hA_AAAA_AAAA;
      1023:    return 36'h2;
      default: return 36'h0;
    endcase
  endfunction

  task automatic test_scan();
    int cyc, hs, stalls, order_bad, data_bad, last_bad, stable_bad, first_bad;
    logic held;
    logic [35:0] hd;
    logic [7:0] hx, hy;
    logic v;
    logic [35:0] d;
    do_write(8'd0, 8'd0, 36'h1);
    do_write(8'd31, 8'd31, 36'h2);
    scan_start = 1'b1; scan_clear = 1'b1;
    read_req = 1'b1; read_x = 8'd7; read_y = 8'd7;
    tick();
    scan_start = 1'b0; scan_clear = 1'b0; read_req = 1'b0;
    checks++;
    if (read_valid !== 1'b1 || read_data !== 36'hA_AAAA_AAAA || busy !== 1'b1) begin
      failures++;
      $display("FAIL scan_start_concurrent valid=%b data=%h busy=%b want valid=1 data=aaaaaaaaa busy=1",
               read_valid, read_data, busy);
    end
    cyc = 0; hs = 0; stalls = 0; order_bad = 0; data_bad = 0; last_bad = 0; stable_bad = 0; first_bad = -1;
    held = 1'b0; hd = '0; hx = '0; hy = '0;
    while (hs < DEPTH && cyc < 6000) begin
      scan_ready = ((cyc % 4) < 2);
      scan_start = (cyc == 50);
      if (held && !(scan_valid === 1'b1 && scan_data === hd && scan_x === hx && scan_y === hy)) stable_bad++;
      held = 1'b0;
      if (scan_valid === 1'b1) begin
        if (scan_x !== 8'(hs % W) || scan_y !== 8'(hs / W)) begin
          order_bad++;
          if (first_bad < 0) first_bad = hs;
        end
        if (scan_data !== scan_expect(hs)) begin
          data_bad++;
          if (first_bad < 0) first_bad = hs;
        end
        if (scan_last !== (hs == DEPTH - 1)) last_bad++;
        if (scan_ready) hs++;
        else begin
          held = 1'b1; hd = scan_data; hx = scan_x; hy = scan_y;
          stalls++;
        end
      end
      cyc++;
      tick();
    end
    scan_ready = 1'b0; scan_start = 1'b0;
    checks++;
    if (hs != DEPTH) begin
      failures++;
      $display("FAIL scan_handshakes got=%0d want=%0d", hs, DEPTH);
    end
    checks++;
    if (order_bad != 0 || data_bad != 0) begin
      failures++;
      $display("FAIL scan_order_data order_errs=%0d data_errs=%0d first_idx=%0d want 0 errors", order_bad, data_bad, first_bad);
    end
    checks++;
    if (last_bad != 0) begin
      failures++;
      $display("FAIL scan_last_flag errs=%0d want=0", last_bad);
    end
    checks++;
    if (stable_bad != 0 || stalls == 0) begin
      failures++;
      $display("FAIL scan_stall_stable unstable=%0d stalls=%0d want unstable=0 stalls>0", stable_bad, stalls);
    end
    checks++;
    if (scan_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL scan_exit valid=%b busy=%b want valid=0 busy=0", scan_valid, busy);
    end
    do_read(8'd0, 8'd0, v, d);
    checks++;
    if (v !== 1'b1 || d !== 36'h0) begin
      failures++;
      $display("FAIL scan_cleared_first valid=%b data=%h want valid=1 data=0", v, d);
    end
    do_read(8'd31, 8'd31, v, d);
    checks++;
    if (d !== 36'h0) begin
      failures++;
      $display("FAIL scan_cleared_last got=%h want=0", d);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc, hs;
    logic v;
    logic [35:0] d;
    do_write(8'd10, 8'd10, 36'h777);
    scan_start = 1'b1; scan_clear = 1'b0; scan_ready = 1'b1;
    tick();
    scan_start = 1'b0;
    cyc = 0; hs = 0;
    while (hs < 100 && cyc < 1000) begin
      if (scan_valid === 1'b1) hs++;
      cyc++;
      tick();
    end
    checks++;
    if (hs != 100) begin
      failures++;
      $display("FAIL midscan_progress got=%0d want=100", hs);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (scan_valid !== 1'b0 || busy !== 1'b1 || scan_last !== 1'b0 || init_done !== 1'b0 || read_valid !== 1'b0) begin
      failures++;
      $display("FAIL midscan_reset valid=%b busy=%b last=%b init_done=%b want valid=0 busy=1 last=0 init_done=0",
               scan_valid, busy, scan_last, init_done);
    end
    scan_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wait_init("reinit");
    do_read(8'd10, 8'd10, v, d);
    checks++;
    if (v !== 1'b1 || d !== 36'h0) begin
      failures++;
      $display("FAIL reinit_cleared valid=%b data=%h want valid=1 data=0", v, d);
    end
  endtask

  initial begin
    test_reset();
    test_read_write();
    test_bypass();
    test_back_to_back();
    test_range();
    test_scan();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fmap_mem_responder.md
Name: fmap_mem_responder

Overview:
- Responder side of the feature-map read/write port pair used by the 2D convolution engine.
- Owns the membrane-potential feature map: one word per (x,y), packing OUT_CHANNELS neurons.
- Serves coordinate-addressed reads with fixed 1-cycle latency and posted writes.
- Zero-initialises the map after reset and streams the whole map to a downstream stage (threshold/pooling) on request, with valid/ready backpressure.

Parameters:
- COORD_BITS, 8: width of each x/y coordinate.
- OUT_CHANNELS, 4: neurons per word.
- IMG_WIDTH, 32: map width.
- IMG_HEIGHT, 32: map height.
- BITS_PER_NEURON, 9: bits per neuron. WORD_W = OUT_CHANNELS*BITS_PER_NEURON; DEPTH = IMG_WIDTH*IMG_HEIGHT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- read_req  in  1  read request.
- read_x, read_y  in  COORD_BITS each  read coordinate.
- read_data  out  WORD_W  read word, registered.
- read_valid  out  1  read_data valid.
- write_req  in  1  write request.
- write_x, write_y  in  COORD_BITS each  write coordinate.
- write_data  in  WORD_W  write word.
- busy  out  1  high in INIT/SCAN; requests are dropped.
- init_done  out  1  sticky high once first clear sweep completes.
- range_err  out  1  one-cycle pulse on out-of-range request.
- scan_start  in  1  start full-map stream.
- scan_clear  in  1  sampled with scan_start; zero each word after it is handed off.
- scan_valid  out  1  stream valid.
- scan_ready  in  1  stream ready.
- scan_data  out  WORD_W  streamed word.
- scan_x, scan_y  out  COORD_BITS each  coordinate of scan_data.
- scan_last  out  1  high with final word (DEPTH-1).

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values: read_data=0, read_valid=0, busy=1, init_done=0, range_err=0, scan_valid=0, scan_data=0, scan_x=0, scan_y=0, scan_last=0. State enters INIT.
- Address: addr = y*IMG_WIDTH + x, row-major. Storage is a simple dual-port array, one read and one write per cycle.

State machine:
- INIT
  - Writes 0 to addr 0..DEPTH-1, one per cycle.
  - On writing DEPTH-1: next state SERVE, busy=0 and init_done=1 from the following cycle.
- SERVE
  - read_req at cycle t: read_data/read_valid are set at t+1; read_valid holds for one cycle per request.
  - Back-to-back reads are allowed every cycle.
  - write_req at cycle t commits at the t edge.
  - Same cycle, same address, read and write: read_data at t+1 = write_data (write-first bypass).
  - Write at t then read of the same address at t+1: returns the new data.
  - scan_start at t with concurrent requests: the requests are served normally, then state SCAN at t+1; busy=1 from t+1.
  - scan_clear is latched at scan_start.
- SCAN
  - Internal pointer starts at addr 0. Read issued in the entry cycle; scan_valid=1 the next cycle, with scan_x/scan_y/scan_last.
  - Outputs are held stable while scan_valid && !scan_ready.
  - On handshake: if the latched clear is set, write 0 to the handed-off address that cycle. The pointer increments and the next read issues; scan_valid drops for one cycle (throughput one word per 2 cycles).
  - Handshake with scan_last: next state SERVE, scan_valid=0, busy=0 the next cycle.
  - scan_start while not in SERVE is ignored.
- Out-of-range request (x>=IMG_WIDTH or y>=IMG_HEIGHT)
  - Writes are dropped.
  - Reads still return read_valid=1 with read_data=0.
  - range_err pulses at t+1. A read and a write both bad in one cycle give a single pulse.
- Requests while busy: dropped, no read_valid, no range_err.
- Reset mid-operation (any state): all outputs return to reset values immediately, and the full INIT sweep is re-run. A scan in progress is abandoned, with no scan_last.
- Arithmetic: no accumulation inside this block; words are stored verbatim.

Test Plan:
- Release reset: busy=1 for exactly 1024 cycles, then busy=0 and init_done=1. Read (3,5) → read_valid next cycle, read_data=0.
- Write (3,5)=36'h0_1234_5678 at t; read (3,5) at t+1 → read_data=36'h0_1234_5678 at t+2. Read (4,5) → 0.
- Same-cycle write (7,7)=36'hA_AAAA_AAAA and read (7,7) → read_data=36'hA_AAAA_AAAA next cycle. Array holds the value on re-read.
- Write (32,0) and read (0,32) → range_err single pulse, read_data=0; (0,0) remains unchanged.
- Preload (0,0)=1 and (31,31)=2, then scan_start with scan_clear=1 and scan_ready toggling 50%:
  - Exactly 1024 handshakes, in order (0,0),(1,0)…(31,31).
  - Word 0 = 1, last word = 2 with scan_last=1.
  - Data stable while stalled.
  - Subsequent reads of (0,0) and (31,31) → 0.
- Assert rst_n low after 100 scan handshakes:
  - scan_valid=0 and busy=1 immediately.
  - After release, a full 1024-cycle INIT runs, then a read of any previously written address → 0.
